bht_update_ctrl: RTL and testbench
==================================

Name: bht_update_ctrl

Overview:
- Sequences all writes into the branch history table.
- After reset, runs an init sweep that clears every BHT entry while prediction is disabled.
- In normal operation, accepts resolved-branch updates from two execute pipes, buffers them in a small in-order FIFO, and drains one update per cycle into the BHT's single write port.
- Sits between the EXE stage(s) and the BHT.

Parameters:
- SET_NUM, 8, BHT sets; power of 2.
- ASSOCIATIVITY, 4, BHT ways; power of 2.
- DEPTH, 4, update FIFO entries; power of 2, ≥ 2.
- INIT_CYCLES (local), SET_NUM*ASSOCIATIVITY, length of the init sweep.
- INIT_BITS (local), $clog2(INIT_CYCLES), width of the sweep counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  pipe-0 resolved branch valid.
- req0_pc  in  32  pipe-0 branch pc.
- req0_dest  in  32  pipe-0 branch target.
- req0_taken  in  1  pipe-0 taken outcome.
- req1_valid / req1_pc / req1_dest / req1_taken  in  1/32/32/1  same fields for pipe 1.
- req_ready  out  1  both pipes may present updates this cycle.
- hold  in  1  freezes FIFO drain; writes suppressed.
- bht_is_write  out  1  BHT write strobe.
- bht_executed_pc  out  32  pc to update.
- bht_dest_pc  out  32  target to install.
- bht_is_taken  out  1  outcome for counter update.
- bht_init  out  1  init sweep active; BHT writes zero at bht_init_addr.
- bht_init_addr  out  INIT_BITS  {index, way} being cleared.
- predict_en  out  1  BHT predictions may be used by fetch.
- busy  out  1  FIFO non-empty or init active.

Behaviour:
- State machine: INIT → RUN.
  - resetn low (async): state=INIT, init_cnt=0, FIFO head/tail/count=0.
  - Reset values: req_ready=0, bht_is_write=0, bht_init=1, bht_init_addr=0, predict_en=0, busy=1.
- INIT:
  - bht_init=1; bht_init_addr=init_cnt; init_cnt increments each cycle.
  - When init_cnt==INIT_CYCLES-1, the next state is RUN; init_cnt wraps to 0.
  - Sweep takes exactly INIT_CYCLES cycles after reset release.
  - req_ready=0, bht_is_write=0, predict_en=0 throughout INIT.
- RUN:
  - bht_init=0, predict_en=1. No path back to INIT except resetn.
- Enqueue:
  - req_ready = (state==RUN) && (count ≤ DEPTH-2), computed from registered count only (no same-cycle dequeue credit).
  - On req_ready, each valid request is written into the FIFO.
  - If both are valid, req0 occupies slot tail and req1 occupies slot tail+1, so program order is pipe 0 then pipe 1.
  - A single valid request (either pipe) consumes one slot.
  - Requests presented while req_ready=0 are ignored; upstream must hold them.
- Dequeue:
  - bht_is_write = (state==RUN) && (count≠0) && !hold.
  - bht_executed_pc, bht_dest_pc and bht_is_taken come from the head entry, driven from registers; fields are don't-care when bht_is_write=0.
  - Head pops on every cycle bht_is_write=1 (the BHT always accepts).
- Latency: an update accepted in cycle N appears on bht_is_write no earlier than cycle N+1. There is no bypass.
- Count:
  - count_next = count + enq_n − deq, where enq_n ∈ {0,1,2}.
  - Simultaneous enqueue and dequeue are legal; count never exceeds DEPTH.
  - Head and tail pointers wrap modulo DEPTH.
- hold=1 stalls the drain with no data loss. Enqueue continues subject to req_ready.
- busy = (state==INIT) || (count≠0).
- Reset asserted mid-operation: buffered updates are discarded and the init sweep restarts from address 0.

Test Plan:
- Reset release with SET_NUM=8, ASSOCIATIVITY=4 → bht_init high for exactly 32 cycles, bht_init_addr steps 0..31, then predict_en=1 and req_ready=1.
- In RUN, pulse req0 only (pc=0x80000010, dest=0x80000100, taken=1) → one cycle later bht_is_write=1 with those fields for exactly 1 cycle, then busy=0.
- Dual request in one cycle (req0 pc=0x100, req1 pc=0x200) → writes emitted in consecutive cycles, 0x100 first then 0x200.
- hold=1 while issuing dual requests for 2 cycles → count reaches 4 and req_ready=0 from count 3 on; after releasing hold, 4 writes emerge in order with no loss.
- Sustained single requests every cycle with no hold → req_ready stays 1 and one write per cycle at a steady state with count ≤ 2.
- Assert resetn low with 3 entries queued → outputs return to reset values immediately; after release, the sweep restarts at addr 0 and the old entries are never written.

Source files
------------

// File: rtl/bht_update_ctrl_if.sv
// Update/write bundle between the execute pipes, the BHT update sequencer and the BHT.
// master = upstream/observer side, slave = the sequencer itself.
interface bht_update_ctrl_if #(
  parameter int INIT_BITS = 5
);
  logic                 req0_valid;
  logic [31:0]          req0_pc;
  logic [31:0]          req0_dest;
  logic                 req0_taken;
  logic                 req1_valid;
  logic [31:0]          req1_pc;
  logic [31:0]          req1_dest;
  logic                 req1_taken;
  logic                 req_ready;
  logic                 hold;
  logic                 bht_is_write;
  logic [31:0]          bht_executed_pc;
  logic [31:0]          bht_dest_pc;
  logic                 bht_is_taken;
  logic                 bht_init;
  logic [INIT_BITS-1:0] bht_init_addr;
  logic                 predict_en;
  logic                 busy;

  modport master (
    output req0_valid, req0_pc, req0_dest, req0_taken,
    output req1_valid, req1_pc, req1_dest, req1_taken,
    output hold,
    input  req_ready, bht_is_write, bht_executed_pc, bht_dest_pc, bht_is_taken,
    input  bht_init, bht_init_addr, predict_en, busy
  );

  modport slave (
    input  req0_valid, req0_pc, req0_dest, req0_taken,
    input  req1_valid, req1_pc, req1_dest, req1_taken,
    input  hold,
    output req_ready, bht_is_write, bht_executed_pc, bht_dest_pc, bht_is_taken,
    output bht_init, bht_init_addr, predict_en, busy
  );
endinterface

// File: rtl/bht_update_ctrl.sv
// BHT write sequencer: post-reset clear sweep, then an in-order FIFO that merges
// resolved branches from two execute pipes onto the single BHT write port.
module bht_update_ctrl #(
  parameter int SET_NUM       = 8,
  parameter int ASSOCIATIVITY = 4,
  parameter int DEPTH         = 4
) (
  input  logic               clk,
  input  logic               resetn,
  bht_update_ctrl_if.slave   bus
);
  localparam int INIT_CYCLES = SET_NUM * ASSOCIATIVITY;
  localparam int INIT_BITS   = $clog2(INIT_CYCLES);
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = $clog2(DEPTH + 1);
  localparam logic [INIT_BITS-1:0] INIT_LAST = INIT_BITS'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     ROOM_MAX  = CNT_W'(DEPTH - 2);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [INIT_BITS-1:0] init_cnt;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W-1:0]     slot1;
  logic [CNT_W-1:0]     count;
  logic                 enq0;
  logic                 enq1;
  logic                 deq;
  logic [1:0]           enq_n;

  logic [31:0]          pc_mem   [DEPTH];
  logic [31:0]          dest_mem [DEPTH];
  logic [DEPTH-1:0]     taken_mem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_INIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_cnt == INIT_LAST) state_nxt = S_RUN;
  end

  // Ready looks only at the registered count, so two slots must be free even if a pop is pending.
  always_comb begin
    bus.bht_init     = (state == S_INIT);
    bus.predict_en   = (state == S_RUN);
    bus.req_ready    = (state == S_RUN) && (count <= ROOM_MAX);
    bus.bht_is_write = (state == S_RUN) && (count != '0) && !bus.hold;
    bus.busy         = (state == S_INIT) || (count != '0);
  end

  assign bus.bht_init_addr   = init_cnt;
  assign bus.bht_executed_pc = pc_mem[head];
  assign bus.bht_dest_pc     = dest_mem[head];
  assign bus.bht_is_taken    = taken_mem[head];

  assign enq0  = bus.req_ready & bus.req0_valid;
  assign enq1  = bus.req_ready & bus.req1_valid;
  assign deq   = bus.bht_is_write;
  assign enq_n = {1'b0, enq0} + {1'b0, enq1};
  // Pipe 1 lands behind pipe 0 when both retire together to keep program order.
  assign slot1 = enq0 ? tail + PTR_W'(1) : tail;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_cnt <= '0;
    end else if (state == S_INIT) begin
      init_cnt <= (init_cnt == INIT_LAST) ? '0 : init_cnt + INIT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + CNT_W'(enq_n) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq0) begin
      pc_mem[tail]    <= bus.req0_pc;
      dest_mem[tail]  <= bus.req0_dest;
      taken_mem[tail] <= bus.req0_taken;
    end
    if (enq1) begin
      pc_mem[slot1]    <= bus.req1_pc;
      dest_mem[slot1]  <= bus.req1_dest;
      taken_mem[slot1] <= bus.req1_taken;
    end
  end
endmodule

// File: tb/tb_bht_update_ctrl.sv
// Bench for bht_update_ctrl: queue-based reference model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_bht_update_ctrl;
  localparam int SET_NUM     = 8;
  localparam int ASSOC       = 4;
  localparam int DEPTH       = 4;
  localparam int INIT_CYCLES = SET_NUM * ASSOC;
  localparam int INIT_BITS   = 5;

  logic clk = 1'b0;
  logic resetn;

  bht_update_ctrl_if #(.INIT_BITS(INIT_BITS)) bif ();

  bht_update_ctrl #(
    .SET_NUM(SET_NUM), .ASSOCIATIVITY(ASSOC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dest;
    logic        taken;
  } upd_t;

  upd_t        mq[$];
  int          sweep_idx = 0;
  logic [31:0] wlog[$];

  // Reference model: sweep position + ordered list of pending updates.
  always @(negedge clk) begin
    bit   in_init;
    bit   exp_ready;
    bit   exp_wr;
    upd_t e;
    if (resetn !== 1'b1) begin
      mq.delete();
      sweep_idx = 0;
    end
    in_init   = (sweep_idx < INIT_CYCLES);
    exp_ready = !in_init && (mq.size() <= DEPTH - 2);
    exp_wr    = !in_init && (mq.size() != 0) && (bif.hold !== 1'b1);
    check("m_init",    64'(bif.bht_init),     64'(in_init));
    check("m_predict", 64'(bif.predict_en),   64'(!in_init));
    check("m_ready",   64'(bif.req_ready),    64'(exp_ready));
    check("m_write",   64'(bif.bht_is_write), 64'(exp_wr));
    check("m_busy",    64'(bif.busy),         64'(in_init || mq.size() != 0));
    if (in_init) check("m_init_addr", 64'(bif.bht_init_addr), 64'(sweep_idx));
    if (exp_wr) begin
      e = mq[0];
      check("m_pc",    64'(bif.bht_executed_pc), 64'(e.pc));
      check("m_dest",  64'(bif.bht_dest_pc),     64'(e.dest));
      check("m_taken", 64'(bif.bht_is_taken),    64'(e.taken));
    end
    if (bif.bht_is_write === 1'b1) wlog.push_back(bif.bht_executed_pc);
    if (resetn === 1'b1) begin
      if (exp_wr) void'(mq.pop_front());
      if (exp_ready) begin
        if (bif.req0_valid) mq.push_back('{bif.req0_pc, bif.req0_dest, bif.req0_taken});
        if (bif.req1_valid) mq.push_back('{bif.req1_pc, bif.req1_dest, bif.req1_taken});
      end
      if (in_init) sweep_idx++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
  endtask

  task automatic set_req0(input logic [31:0] pc, input logic [31:0] dest, input logic taken);
    bif.req0_valid = 1'b1; bif.req0_pc = pc; bif.req0_dest = dest; bif.req0_taken = taken;
  endtask

  task automatic set_req1(input logic [31:0] pc, input logic [31:0] dest, input logic taken);
    bif.req1_valid = 1'b1; bif.req1_pc = pc; bif.req1_dest = dest; bif.req1_taken = taken;
  endtask

  task automatic run_sweep();
    int n;
    n = 0;
    while (bif.bht_init === 1'b1 && n < 100) begin
      check("init_addr", 64'(bif.bht_init_addr), 64'(n));
      n++;
      step();
    end
    check("init_len",     64'(n), 64'd32);
    check("run_predict",  64'(bif.predict_en), 64'd1);
    check("run_ready",    64'(bif.req_ready), 64'd1);
  endtask

  initial begin
    int base;
    int stale;
    resetn = 1'b0;
    bif.hold = 1'b0;
    bif.req0_pc = '0; bif.req0_dest = '0; bif.req0_taken = 1'b0;
    bif.req1_pc = '0; bif.req1_dest = '0; bif.req1_taken = 1'b0;
    idle();
    #1;
    check("rst_ready", 64'(bif.req_ready),    64'd0);
    check("rst_write", 64'(bif.bht_is_write), 64'd0);
    check("rst_init",  64'(bif.bht_init),     64'd1);
    check("rst_busy",  64'(bif.busy),         64'd1);
    repeat (3) step();
    resetn = 1'b1;
    run_sweep();

    // Single request from pipe 0
    set_req0(32'h8000_0010, 32'h8000_0100, 1'b1);
    step();
    idle();
    check("single_wr",    64'(bif.bht_is_write),    64'd1);
    check("single_pc",    64'(bif.bht_executed_pc), 64'h8000_0010);
    check("single_dest",  64'(bif.bht_dest_pc),     64'h8000_0100);
    check("single_taken", 64'(bif.bht_is_taken),    64'd1);
    step();
    check("single_done",  64'(bif.bht_is_write), 64'd0);
    check("single_idle",  64'(bif.busy),         64'd0);

    // Dual request: pipe 0 before pipe 1
    set_req0(32'h100, 32'h1100, 1'b0);
    set_req1(32'h200, 32'h1200, 1'b1);
    step();
    idle();
    check("dual_first",  64'(bif.bht_executed_pc), 64'h100);
    check("dual_wr1",    64'(bif.bht_is_write),    64'd1);
    step();
    check("dual_second", 64'(bif.bht_executed_pc), 64'h200);
    check("dual_wr2",    64'(bif.bht_is_write),    64'd1);
    step();
    check("dual_done",   64'(bif.bht_is_write),    64'd0);

    // Fill under hold, then drain in order
    bif.hold = 1'b1;
    set_req0(32'h300, 32'h1300, 1'b1);
    set_req1(32'h400, 32'h1400, 1'b0);
    step();
    check("hold_ready2", 64'(bif.req_ready),    64'd1);
    check("hold_nowr",   64'(bif.bht_is_write), 64'd0);
    set_req0(32'h500, 32'h1500, 1'b1);
    set_req1(32'h600, 32'h1600, 1'b0);
    step();
    idle();
    check("hold_full",   64'(bif.req_ready),    64'd0);
    check("hold_busy",   64'(bif.busy),         64'd1);
    step();
    check("hold_still",  64'(bif.bht_is_write), 64'd0);
    bif.hold = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_wr", 64'(bif.bht_is_write),    64'd1);
      check("drain_pc", 64'(bif.bht_executed_pc), 64'(32'h300 + 32'h100 * i));
      step();
    end
    check("drain_done", 64'(bif.bht_is_write), 64'd0);

    // Sustained single requests
    for (int i = 0; i < 20; i++) begin
      set_req0(32'h1000 + i, 32'h2000 + i, i[0]);
      step();
      check("sus_ready", 64'(bif.req_ready),       64'd1);
      check("sus_pc",    64'(bif.bht_executed_pc), 64'(32'h1000 + i));
    end
    idle();
    repeat (4) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bif.hold       = ($urandom_range(0, 3) == 0);
      bif.req0_valid = $urandom_range(0, 1) == 1;
      bif.req1_valid = $urandom_range(0, 1) == 1;
      bif.req0_pc    = $urandom; bif.req0_dest = $urandom; bif.req0_taken = $urandom_range(0, 1) == 1;
      bif.req1_pc    = $urandom; bif.req1_dest = $urandom; bif.req1_taken = $urandom_range(0, 1) == 1;
      step();
    end
    idle();
    bif.hold = 1'b0;
    repeat (8) step();

    // Reset with three entries queued
    bif.hold = 1'b1;
    set_req0(32'hDEAD_0001, 32'h0, 1'b1);
    set_req1(32'hDEAD_0002, 32'h0, 1'b1);
    step();
    bif.req1_valid = 1'b0;
    set_req0(32'hDEAD_0003, 32'h0, 1'b1);
    step();
    idle();
    check("pre_rst_ready", 64'(bif.req_ready), 64'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_ready",   64'(bif.req_ready),     64'd0);
    check("mid_rst_write",   64'(bif.bht_is_write),  64'd0);
    check("mid_rst_init",    64'(bif.bht_init),      64'd1);
    check("mid_rst_addr",    64'(bif.bht_init_addr), 64'd0);
    check("mid_rst_predict", 64'(bif.predict_en),    64'd0);
    check("mid_rst_busy",    64'(bif.busy),          64'd1);
    bif.hold = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    base = wlog.size();
    run_sweep();
    repeat (10) step();
    stale = 0;
    for (int i = base; i < wlog.size(); i++)
      if (wlog[i][31:16] == 16'hDEAD) stale++;
    check("stale_writes", 64'(stale), 64'd0);
    check("post_rst_writes", 64'(wlog.size() - base), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
